decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Instruction-decode stage directly downstream of the 16-bit fetch stage. Decodes
//  instruction/PC_out/valid from fetch into an ID/EX pipeline register and detects
//  load-use hazards, stalling fetch when one occurs. Resolves JMP and predicts BEQ
//  with a 16-entry 2-bit counter table, driving a redirect PC back to fetch.
// PARAMETERS
//  BHT_IDX_W   4   predictor index width; table has 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W-1:0]
//  BHT_INIT    2'b01  counter value after reset (weakly not-taken)
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  instruction_in  in   16  instruction from fetch
//  pc_in           in   8   PC of instruction_in
//  valid_in        in   1   instruction_in is valid
//  flush           in   1   EX mispredict: discard instruction currently being decoded
//  ex_resolve_valid in  1   a BEQ resolved in EX this cycle
//  ex_resolve_pc   in   8   PC of the resolved BEQ
//  ex_resolve_taken in  1   actual BEQ outcome
//  stall           out  1   hold fetch (comb.)
//  redirect        out  1   fetch must load redirect_pc next (comb.)
//  redirect_pc     out  8   JMP target or predicted BEQ target (comb.)
//  id_valid        out  1   ID/EX register holds a real instruction
//  id_opcode       out  4   decoded opcode
//  id_rd/id_rs1/id_rs2 out 4 each  register fields (0 when unused)
//  id_imm          out  8   sign-extended imm4 / offset
//  id_pc           out  8   PC of the ID/EX instruction
//  id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_pred_taken  out 1 each
//  id_illegal      out  1   opcode B..E decoded
//  halted          out  1   sticky: HALT has been decoded
// BEHAVIOUR
//  ISA op=[15:12]: 0 NOP; 1-5 ADD/SUB/AND/OR/XOR rd=[11:8] rs1=[7:4] rs2=[3:0];
//   6 ADDI rd,rs1,imm4=[3:0]; 7 LOAD rd,[rs1+imm4]; 8 STORE rs2=[11:8] -> [rs1+imm4];
//   9 BEQ rs1=[11:8],rs2=[7:4],off4=[3:0]; A JMP target=[11:4]; B-E illegal (NOP + id_illegal); F HALT.
//  - Register r0 is constant: id_reg_write=0 when rd==0; r0 never causes a hazard.
//  - All id_* outputs register 1 cycle after inputs; stall/redirect/redirect_pc are comb. from inputs + ID/EX.
//  - Reset: all id_* = 0 (bubble), halted=0, every BHT counter = BHT_INIT; stall=redirect=0 follow.
//  - Decode qualifier dq = valid_in & ~flush & ~halted.
//  - Load-use: hz = dq & id_valid & id_mem_read & id_rd!=0 & (id_rd matches any source reg of instruction_in).
//    hz -> stall=1, ID/EX loads a bubble (id_valid=0), redirect=0; the same instruction is re-presented next cycle.
//  - Otherwise dq -> ID/EX loads decoded fields, id_valid=1; ~dq -> bubble.
//  - JMP (dq & ~hz): redirect=1, redirect_pc=[11:4].
//  - BEQ (dq & ~hz): target = pc_in + 1 + sext(off4), modulo 256 (wraps 8'hFF->8'h00);
//    pred = BHT[pc_in idx][1]; redirect=pred, redirect_pc=target; id_pred_taken=pred; id_imm=sext(off4).
//  - BHT update on ex_resolve_valid: taken -> sat. increment (max 11), else sat. decrement (min 00).
//    Update occurs regardless of flush/stall/halted. Same-cycle read/write of one entry: read returns old value.
//  - flush: overrides hz (stall=0, redirect=0), ID/EX gets bubble.
//  - HALT (dq & ~hz): passes to ID/EX with id_valid=1, op=F; halted set at that edge; afterwards
//    every input is bubbled, stall=redirect=0, until reset. A flushed HALT does not set halted.
//  - Reset asserted mid-stall or mid-redirect: all state cleared at that edge; nothing carried over.
// TESTING
//  1 reset, then ADD r1,r2,r3 (16'h1123) pc=5 -> next cycle id_valid=1 id_rd=1 id_rs1=2 id_rs2=3 id_reg_write=1 id_pc=5.
//  2 LOAD r4 (16'h7450) then ADD r5,r4,r1 (16'h1541) -> stall=1 one cycle, bubble in ID/EX, ADD issued the cycle after.
//  3 BEQ pc=8'hFE off=-1 (16'h912F), fresh BHT -> redirect=0; after two taken resolves at pc FE -> redirect=1 redirect_pc=8'hFE.
//  4 BEQ pc=8'hFF off=+1 (16'h9121) with counter=11 -> redirect_pc=8'h01 (wrap); resolve taken at 11 stays 11.
//  5 LOAD-use hazard with flush=1 same cycle -> stall=0, redirect=0, id_valid=0 next cycle.
//  6 HALT (16'hF000) -> id_valid=1 op=F, halted=1; later ADD with valid_in=1 -> id_valid=0; reset -> halted=0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage for the 16-bit pipeline: fills the ID/EX register, detects load-use
// hazards, resolves JMP and predicts BEQ with a table of 2-bit saturating counters.
module decode_stage #(
  parameter int         BHT_IDX_W = 4,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction_in,
  input  logic [7:0]  pc_in,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        ex_resolve_valid,
  input  logic [7:0]  ex_resolve_pc,
  input  logic        ex_resolve_taken,
  output logic        stall,
  output logic        redirect,
  output logic [7:0]  redirect_pc,
  output logic        id_valid,
  output logic [3:0]  id_opcode,
  output logic [3:0]  id_rd,
  output logic [3:0]  id_rs1,
  output logic [3:0]  id_rs2,
  output logic [7:0]  id_imm,
  output logic [7:0]  id_pc,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_is_branch,
  output logic        id_pred_taken,
  output logic        id_illegal,
  output logic        halted
);

  localparam int BHT_N = 2 ** BHT_IDX_W;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       pred_taken;
    logic       illegal;
  } id_t;

  id_t                  id_q, id_d, dec;
  logic                 halted_q, halted_d;
  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [3:0]           op;
  logic [7:0]           imm_sext;
  logic [7:0]           br_target;
  logic                 pred;
  logic                 dq;
  logic                 hz;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic                 unused_resolve_pc;

  assign unused_resolve_pc = ^ex_resolve_pc;

  // Unused register fields stay 0, so source-vs-rd compares never match on them.
  always_comb begin
    op        = instruction_in[15:12];
    imm_sext  = {{4{instruction_in[3]}}, instruction_in[3:0]};
    rd_idx    = pc_in[BHT_IDX_W-1:0];
    pred      = bht_q[rd_idx][1];
    br_target = pc_in + 8'd1 + imm_sext;
    dec        = '0;
    dec.valid  = 1'b1;
    dec.opcode = op;
    dec.pc     = pc_in;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        dec.rd  = instruction_in[11:8];
        dec.rs1 = instruction_in[7:4];
        dec.rs2 = instruction_in[3:0];
      end
      OP_ADDI, OP_LOAD: begin
        dec.rd       = instruction_in[11:8];
        dec.rs1      = instruction_in[7:4];
        dec.imm      = imm_sext;
        dec.mem_read = (op == OP_LOAD);
      end
      OP_STORE: begin
        dec.rs2       = instruction_in[11:8];
        dec.rs1       = instruction_in[7:4];
        dec.imm       = imm_sext;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.rs1        = instruction_in[11:8];
        dec.rs2        = instruction_in[7:4];
        dec.imm        = imm_sext;
        dec.is_branch  = 1'b1;
        dec.pred_taken = pred;
      end
      4'hB, 4'hC, 4'hD, 4'hE: dec.illegal = 1'b1;
      default: ;
    endcase
    dec.reg_write = (dec.rd != 4'd0);
    dq = valid_in & ~flush & ~halted_q;
    hz = dq & id_q.valid & id_q.mem_read & (id_q.rd != 4'd0) &
         ((dec.rs1 == id_q.rd) | (dec.rs2 == id_q.rd));
  end

  always_comb begin
    id_d        = '0;
    halted_d    = halted_q;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    if (hz) begin
      stall = 1'b1;
    end else if (dq) begin
      id_d = dec;
      if (op == OP_HALT) halted_d = 1'b1;
      if (op == OP_JMP) begin
        redirect    = 1'b1;
        redirect_pc = instruction_in[11:4];
      end
      if (op == OP_BEQ) begin
        redirect    = pred;
        redirect_pc = br_target;
      end
    end
  end

  // Training ignores flush/stall/halt; a same-cycle lookup above still sees the old counter.
  always_comb begin
    wr_idx = ex_resolve_pc[BHT_IDX_W-1:0];
    bht_d  = bht_q;
    if (ex_resolve_valid) begin
      if (ex_resolve_taken && bht_q[wr_idx] != 2'b11)
        bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
      else if (!ex_resolve_taken && bht_q[wr_idx] != 2'b00)
        bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q     <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_INIT;
    end else begin
      id_q     <= id_d;
      halted_q <= halted_d;
      bht_q    <= bht_d;
    end
  end

  assign id_valid      = id_q.valid;
  assign id_opcode     = id_q.opcode;
  assign id_rd         = id_q.rd;
  assign id_rs1        = id_q.rs1;
  assign id_rs2        = id_q.rs2;
  assign id_imm        = id_q.imm;
  assign id_pc         = id_q.pc;
  assign id_reg_write  = id_q.reg_write;
  assign id_mem_read   = id_q.mem_read;
  assign id_mem_write  = id_q.mem_write;
  assign id_is_branch  = id_q.is_branch;
  assign id_pred_taken = id_q.pred_taken;
  assign id_illegal    = id_q.illegal;
  assign halted        = halted_q;

endmodule
